// File: rtl/dice_pkg.sv
// Shared types and constants for the multi-die roller: FSM states and the
// face-to-pip lookup for the 7-LED die pattern.
package dice_pkg;

    localparam int PIP_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        SHOW = 2'd2
    } state_t;

    // Bit order b6..b0 = BR, MR, TR, C, BL, ML, TL; entry 0 is the blank die.
    localparam logic [PIP_W-1:0] FACE_PIPS [0:6] = '{
        7'b0000000,
        7'b0001000,
        7'b1000001,
        7'b1001001,
        7'b1010101,
        7'b1011101,
        7'b1110111
    };

    function automatic logic [PIP_W-1:0] face_pips(input logic [2:0] face);
        logic [PIP_W-1:0] pips;
        if (face <= 3'd6) begin
            pips = FACE_PIPS[face];
        end else begin
            pips = {PIP_W{1'b0}};
        end
        return pips;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser and stability counter for an active-low push button;
// emits the debounced press level plus one-cycle rise/fall pulses.
module button_debouncer #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_n,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          rise_r;
    logic          fall_r;
    logic [CW-1:0] cnt_r;
    logic          press_s;

    assign press_s = ~sync2_r;
    assign level   = level_r;
    assign rise    = rise_r;
    assign fall    = fall_r;

    // Synchroniser resets to the released level so a held button must re-qualify
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= button_n;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYC cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CW{1'b0}};
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (press_s == level_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CW'(DEBOUNCE_CYC - 1)) begin
                cnt_r   <= {CW{1'b0}};
                level_r <= press_s;
                rise_r  <= press_s;
                fall_r  <= ~press_s;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dice_roller.sv
// Multi-die electronic dice: debounced button, chained face counters, FSM and
// pip LED output. Optional rolling animation with DICE_ROLLER_ANIM_EN.
module dice_roller
    import dice_pkg::*;
#(
    parameter int NUM_DICE     = 2,
    parameter int FACES        = 6,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int ANIM_DIV     = 5000000
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      BUTTON_N,
    output logic [PIP_W*NUM_DICE-1:0] LED,
    output logic [3*NUM_DICE-1:0]     VALUE,
    output logic                      ROLLING,
    output logic                      DONE
);
    localparam logic [2:0] FACE_MAX = 3'(FACES);

    if (NUM_DICE < 1 || NUM_DICE > 4 || FACES < 2 || FACES > 6 ||
        DEBOUNCE_CYC < 1 || ANIM_DIV < 1) begin : g_param_check
        $error("dice_roller: parameter out of range");
    end

    logic                      press_lvl_s;
    logic                      rise_s;
    logic                      fall_s;
    state_t                    state_r;
    state_t                    state_n;
    logic [2:0]                cnt_r [NUM_DICE];
    logic [NUM_DICE-1:0]       inc_s;
    logic [3*NUM_DICE-1:0]     cnt_flat_s;
    logic [PIP_W*NUM_DICE-1:0] cnt_pips_s;
    logic [3*NUM_DICE-1:0]     value_n;
    logic [PIP_W*NUM_DICE-1:0] value_pips_s;
    logic [PIP_W*NUM_DICE-1:0] led_n;
    logic                      latch_s;
    logic [3*NUM_DICE-1:0]     value_r;
    logic [PIP_W*NUM_DICE-1:0] led_r;
    logic                      rolling_r;
    logic                      done_r;

    button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk      (CLK),
        .rst      (RST),
        .button_n (BUTTON_N),
        .level    (press_lvl_s),
        .rise     (rise_s),
        .fall     (fall_s)
    );

    // Ripple carry: die i steps only when every lower die wraps this cycle
    always_comb begin : carry_chain
        logic carry_v;
        carry_v = (state_r == ROLL);
        inc_s   = {NUM_DICE{1'b0}};
        for (int i = 0; i < NUM_DICE; i++) begin
            inc_s[i] = carry_v;
            carry_v  = carry_v && (cnt_r[i] == FACE_MAX);
        end
    end

    // Face counters, each wrapping FACES -> 1
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_DICE; i++) begin
            if (RST) begin
                cnt_r[i] <= 3'd1;
            end else if (inc_s[i]) begin
                cnt_r[i] <= (cnt_r[i] == FACE_MAX) ? 3'd1 : cnt_r[i] + 3'd1;
            end else begin
                cnt_r[i] <= cnt_r[i];
            end
        end
    end

    // Next-state logic; a low level in ROLL also ends the roll should a pulse be lost
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s) state_n = ROLL;
                else        state_n = IDLE;
            end
            ROLL: begin
                if (fall_s || !press_lvl_s) state_n = SHOW;
                else                        state_n = ROLL;
            end
            SHOW: begin
                if (rise_s) state_n = ROLL;
                else        state_n = SHOW;
            end
            default: state_n = IDLE;
        endcase
    end

    // Flatten counters and translate counters and next VALUE into pip patterns
    always_comb begin
        latch_s = (state_r == ROLL) && (state_n == SHOW);
        for (int i = 0; i < NUM_DICE; i++) begin
            cnt_flat_s[3*i +: 3] = cnt_r[i];
        end
        if (latch_s) begin
            value_n = cnt_flat_s;
        end else begin
            value_n = value_r;
        end
        for (int i = 0; i < NUM_DICE; i++) begin
            cnt_pips_s[PIP_W*i +: PIP_W]   = face_pips(cnt_r[i]);
            value_pips_s[PIP_W*i +: PIP_W] = face_pips(value_n[3*i +: 3]);
        end
    end

`ifdef DICE_ROLLER_ANIM_EN
    localparam int AW = $clog2(ANIM_DIV + 1);
    logic [AW-1:0] anim_r;
    logic          anim_wrap_s;

    assign anim_wrap_s = (anim_r == AW'(ANIM_DIV - 1));

    // Frame timer runs only while staying in ROLL
    always_ff @(posedge CLK) begin
        if (RST || state_r != ROLL || state_n != ROLL) begin
            anim_r <= {AW{1'b0}};
        end else if (anim_wrap_s) begin
            anim_r <= {AW{1'b0}};
        end else begin
            anim_r <= anim_r + AW'(1);
        end
    end

    // LED source: first frame on entry to ROLL, then a fresh frame per wrap
    always_comb begin
        led_n = {PIP_W*NUM_DICE{1'b0}};
        case (state_n)
            IDLE: led_n = {PIP_W*NUM_DICE{1'b0}};
            ROLL: begin
                if (state_r != ROLL || anim_wrap_s) led_n = cnt_pips_s;
                else                                led_n = led_r;
            end
            SHOW:    led_n = value_pips_s;
            default: led_n = {PIP_W*NUM_DICE{1'b0}};
        endcase
    end
`else
    // LED source: dark while rolling, result pattern once shown
    always_comb begin
        led_n = {PIP_W*NUM_DICE{1'b0}};
        case (state_n)
            IDLE:    led_n = {PIP_W*NUM_DICE{1'b0}};
            ROLL:    led_n = {PIP_W*NUM_DICE{1'b0}};
            SHOW:    led_n = value_pips_s;
            default: led_n = {PIP_W*NUM_DICE{1'b0}};
        endcase
    end
`endif

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            value_r   <= {3*NUM_DICE{1'b0}};
            led_r     <= {PIP_W*NUM_DICE{1'b0}};
            rolling_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            value_r   <= value_n;
            led_r     <= led_n;
            rolling_r <= (state_n == ROLL);
            done_r    <= latch_s;
        end
    end

    assign LED     = led_r;
    assign VALUE   = value_r;
    assign ROLLING = rolling_r;
    assign DONE    = done_r;

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller: random press lengths against a
// combination-index model of the dice (index advances once per roll cycle).
module tb_dice_roller;
    localparam int ND   = 2;
    localparam int NF   = 6;
    localparam int DCYC = 4;
    localparam int ADIV = 3;
    localparam int LAT  = 2 + DCYC + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            button_n = 1'b1;
    logic [7*ND-1:0] led;
    logic [3*ND-1:0] value;
    logic            rolling;
    logic            done;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_idx    = 0;

    dice_roller #(.NUM_DICE(ND), .FACES(NF), .DEBOUNCE_CYC(DCYC), .ANIM_DIV(ADIV)) dut (
        .CLK(clk), .RST(rst), .BUTTON_N(button_n),
        .LED(led), .VALUE(value), .ROLLING(rolling), .DONE(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] pips_of(input int face);
        case (face)
            1:       return 7'b0001000;
            2:       return 7'b1000001;
            3:       return 7'b1001001;
            4:       return 7'b1010101;
            5:       return 7'b1011101;
            6:       return 7'b1110111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Die i shows digit i of the base-NF combination index, plus one.
    function automatic logic [3*ND-1:0] value_of(input int idx);
        logic [3*ND-1:0] v;
        int r;
        r = idx % (NF ** ND);
        for (int i = 0; i < ND; i++) begin
            v[3*i +: 3] = 3'((r % NF) + 1);
            r = r / NF;
        end
        return v;
    endfunction

    function automatic logic [7*ND-1:0] leds_of(input logic [3*ND-1:0] v);
        logic [7*ND-1:0] l;
        for (int i = 0; i < ND; i++) begin
            l[7*i +: 7] = pips_of(int'(v[3*i +: 3]));
        end
        return l;
    endfunction

    // Press for 'hold' cycles, release, and record what the DUT did.
    task automatic press_release(input int hold, output int rise_at, output int k,
                                 output int n_done, output logic [3*ND-1:0] v_done,
                                 output logic [7*ND-1:0] l_done, output int led_bad,
                                 output int val_bad);
        logic [3*ND-1:0] v_before;
        logic [7*ND-1:0] exp_led;
        int idx0;
        v_before = value;
        idx0     = model_idx;
        rise_at  = -1;
        k        = 0;
        n_done   = 0;
        v_done   = '0;
        l_done   = '0;
        led_bad  = 0;
        val_bad  = 0;
        button_n = 1'b0;
        for (int c = 1; c <= hold + 30; c++) begin
            if (c == hold + 1) button_n = 1'b1;
            step();
            if (rolling) begin
                if (rise_at < 0) rise_at = c;
`ifdef DICE_ROLLER_ANIM_EN
                exp_led = leds_of(value_of(idx0 + ((k < ADIV) ? 0 : ADIV * (k / ADIV) - 1)));
`else
                exp_led = '0;
`endif
                if (led !== exp_led) led_bad++;
                if (value !== v_before) val_bad++;
                k++;
            end
            if (done) begin
                n_done++;
                v_done = value;
                l_done = led;
            end
        end
    endtask

    task automatic check_roll(input string name, input int hold);
        int rise_at, k, n_done, led_bad, val_bad;
        logic [3*ND-1:0] v_done, exp_v;
        logic [7*ND-1:0] l_done;
        exp_v = value_of(model_idx + hold - 1);
        press_release(hold, rise_at, k, n_done, v_done, l_done, led_bad, val_bad);
        model_idx = (model_idx + hold) % (NF ** ND);
        tests_run += 6;
        if (rise_at !== LAT) begin
            tests_failed++; $display("FAIL %s rise_latency: got %0d want %0d", name, rise_at, LAT);
        end
        if (k !== hold) begin
            tests_failed++; $display("FAIL %s roll_cycles: got %0d want %0d", name, k, hold);
        end
        if (n_done !== 1) begin
            tests_failed++; $display("FAIL %s done_pulses: got %0d want 1", name, n_done);
        end
        if (v_done !== exp_v) begin
            tests_failed++; $display("FAIL %s value: got %b want %b", name, v_done, exp_v);
        end
        if (l_done !== leds_of(exp_v)) begin
            tests_failed++; $display("FAIL %s led: got %b want %b", name, l_done, leds_of(exp_v));
        end
        if (led_bad !== 0 || val_bad !== 0) begin
            tests_failed++; $display("FAIL %s roll_outputs: led_bad %0d val_bad %0d want 0 0", name, led_bad, val_bad);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        model_idx = 0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (led !== '0 || value !== '0 || rolling !== 1'b0 || done !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++; $display("FAIL reset_idle: %0d bad cycles want 0 (led %b value %b)", bad, led, value);
        end
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        button_n = 1'b0;
        for (int c = 0; c < 3; c++) step();
        button_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (rolling || done) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++; $display("FAIL glitch: %0d active cycles want 0", seen);
        end
    endtask

    // 36 counter steps before the latch cycle visit every combination once.
    task automatic test_full_wrap();
        logic [3*ND-1:0] ones;
        ones = value_of(0);
        tests_run++;
        if (value_of(model_idx + 36) !== ones) begin
            tests_failed++; $display("FAIL full_wrap_start: model idx %0d want 0", model_idx);
        end
        check_roll("full_wrap", 37);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            check_roll($sformatf("rand%0d", r), int'($urandom_range(8, 60)));
        end
    endtask

    task automatic test_rst_mid_roll();
        int waited;
        waited = 0;
        button_n = 1'b0;
        while (!rolling && waited < 50) begin
            step();
            waited++;
        end
        tests_run++;
        if (!rolling) begin
            tests_failed++; $display("FAIL rst_roll_start: rolling %b want 1", rolling);
        end
        for (int c = 0; c < 10; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_idx = 0;
        tests_run++;
        if (led !== '0 || value !== '0 || rolling !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_roll: led %b value %b rolling %b done %b want all 0", led, value, rolling, done);
        end
        check_roll("held_after_rst", 20);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_full_wrap();
        check_roll("hold40", 40);
        test_back_to_back();
        test_rst_mid_roll();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
